// File: rtl/spi_poll_pkg.sv
// Shared definitions for the SPI poll controller: SPI core register map,
// CTRL bit positions, FSM state encoding and constant helpers.
package spi_poll_pkg;

  localparam logic [4:0] ADR_RX0     = 5'h00;
  localparam logic [4:0] ADR_TX0     = 5'h00;
  localparam logic [4:0] ADR_CTRL    = 5'h10;
  localparam logic [4:0] ADR_DIVIDER = 5'h14;
  localparam logic [4:0] ADR_SS      = 5'h18;

  localparam int unsigned CTRL_CHAR_LEN_MSB = 6;
  localparam int unsigned CTRL_GO_BSY       = 8;
  localparam int unsigned CTRL_TX_NEG       = 10;
  localparam int unsigned CTRL_ASS          = 13;

  localparam int unsigned POLL_TIMEOUT_READS = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DIV,
    S_WR_SS,
    S_WR_TX,
    S_WR_CTRL,
    S_POLL,
    S_RD_RX,
    S_DONE
  } state_t;

  // Low-order mask covering len bits; len of 32 yields all ones.
  function automatic logic [31:0] char_mask(input logic [6:0] len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < 32'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [6:0] len);
    logic [31:0] w;
    w = '0;
    w[CTRL_CHAR_LEN_MSB:0] = len;
    w[CTRL_GO_BSY]         = 1'b1;
    w[CTRL_TX_NEG]         = 1'b1;
    w[CTRL_ASS]            = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/wishbone_b3.sv
// Single-beat Wishbone B3 bundle between the poll controller and the SPI core
// (5-bit word address, 32-bit data).
interface wishbone_b3;
  logic [4:0]  adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_m2s, sel, cyc, stb, we,
    input  dat_s2m, ack, err, rty
  );

  modport slave (
    input  adr, dat_m2s, sel, cyc, stb, we,
    output dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/spi_poll_timer.sv
// Free-running poll period counter: ticks once every PERIOD cycles while
// enable is high and restarts from PERIOD-1 whenever enable drops.
module spi_poll_timer #(
  parameter logic [31:0] PERIOD = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || !enable || r_count == '0) r_count <= PERIOD - 32'd1;
    else                                 r_count <= r_count - 32'd1;
  end

  assign tick = enable && (r_count == '0);

endmodule

// File: rtl/spi_poll_ctrl.sv
// Periodic / on-demand SPI sampler driving an SPI core over Wishbone.
// Optional macro SPI_POLL_TIMEOUT_EN aborts after 1024 busy GO_BSY reads.
module spi_poll_ctrl
  import spi_poll_pkg::*;
#(
  parameter logic [15:0] DIVIDER  = 16'd4,
  parameter logic [6:0]  CHAR_LEN = 7'd16,
  parameter logic [7:0]  SS_MASK  = 8'h01,
  parameter logic [31:0] PERIOD   = 32'd1_000_000,
  parameter logic [31:0] TX_WORD  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  wishbone_b3.master        master,
  input  logic              enable,
  input  logic              start,
  output logic              busy,
  output logic [31:0]       sample,
  output logic              sample_valid,
  output logic              error
);

  localparam logic [31:0] SAMPLE_MASK = char_mask(CHAR_LEN);
  localparam logic [31:0] CTRL_VALUE  = ctrl_word(CHAR_LEN);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_cyc;
  logic        r_we;
  logic [4:0]  r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rx;
  logic [31:0] r_sample;
  logic        r_sample_valid;
  logic        r_error;
  logic        r_pending;

  logic        w_tick;
  logic        w_ack;
  logic        w_err;
  logic        w_busy_bit;
  logic        w_timeout;
  logic        w_abort;
  logic        w_leave_idle;
  logic        w_issue;
  logic [4:0]  w_adr;
  logic        w_we;
  logic [31:0] w_dat;
  logic        w_unused_rty;

  spi_poll_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (w_tick)
  );

  assign w_ack        = r_cyc && master.ack;
  assign w_err        = r_cyc && master.err;
  assign w_busy_bit   = master.dat_s2m[CTRL_GO_BSY];
  assign w_leave_idle = (r_state == S_IDLE) && r_pending;
  assign w_unused_rty = master.rty;

`ifdef SPI_POLL_TIMEOUT_EN
  logic [9:0] r_poll_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_POLL)  r_poll_cnt <= '0;
    else if (w_ack && w_busy_bit)  r_poll_cnt <= r_poll_cnt + 10'd1;
  end

  assign w_timeout = (r_state == S_POLL) && w_ack && w_busy_bit &&
                     (r_poll_cnt == 10'(POLL_TIMEOUT_READS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_abort = w_err || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (r_pending)               w_next_state = S_WR_DIV;
        S_WR_DIV:  if (w_ack)                   w_next_state = S_WR_SS;
        S_WR_SS:   if (w_ack)                   w_next_state = S_WR_TX;
        S_WR_TX:   if (w_ack)                   w_next_state = S_WR_CTRL;
        S_WR_CTRL: if (w_ack)                   w_next_state = S_POLL;
        S_POLL:    if (w_ack && !w_busy_bit)    w_next_state = S_RD_RX;
        S_RD_RX:   if (w_ack)                   w_next_state = S_DONE;
        S_DONE:                                 w_next_state = S_IDLE;
        default:                                w_next_state = S_IDLE;
      endcase
    end
  end

  // Access payload follows the state being entered, so the first write is
  // launched on the same edge that leaves IDLE; an access is only issued from
  // a cycle with cyc low, which leaves one idle cycle between accesses.
  always_comb begin
    w_adr = '0;
    w_we  = 1'b0;
    w_dat = '0;
    case (w_next_state)
      S_WR_DIV: begin
        w_adr = ADR_DIVIDER;
        w_we  = 1'b1;
        w_dat = {16'h0000, DIVIDER};
      end
      S_WR_SS: begin
        w_adr = ADR_SS;
        w_we  = 1'b1;
        w_dat = {24'h000000, SS_MASK};
      end
      S_WR_TX: begin
        w_adr = ADR_TX0;
        w_we  = 1'b1;
        w_dat = TX_WORD;
      end
      S_WR_CTRL: begin
        w_adr = ADR_CTRL;
        w_we  = 1'b1;
        w_dat = CTRL_VALUE;
      end
      S_POLL:  w_adr = ADR_CTRL;
      S_RD_RX: w_adr = ADR_RX0;
      default: ;
    endcase
    w_issue = !r_cyc && (w_next_state != S_IDLE) && (w_next_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (r_cyc) begin
      if (master.ack || master.err) r_cyc <= 1'b0;
    end else if (w_issue) begin
      r_cyc <= 1'b1;
      r_we  <= w_we;
      r_adr <= w_adr;
      r_dat <= w_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx           <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_error        <= 1'b0;
      r_pending      <= 1'b0;
    end else begin
      r_error        <= w_abort;
      r_sample_valid <= (r_state == S_DONE);
      if (r_state == S_RD_RX && w_ack) r_rx     <= master.dat_s2m;
      if (r_state == S_DONE)           r_sample <= r_rx & SAMPLE_MASK;
      r_pending <= start || w_tick || (r_pending && !w_leave_idle);
    end
  end

  assign master.cyc     = r_cyc;
  assign master.stb     = r_cyc;
  assign master.we      = r_we;
  assign master.adr     = r_adr;
  assign master.dat_m2s = r_dat;
  assign master.sel     = 4'hF;

  assign busy         = (r_state != S_IDLE);
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_spi_poll_ctrl.sv
// Directed bench for spi_poll_ctrl: Wishbone slave model with one-cycle ack,
// scripted GO_BSY responses and error injection, hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_poll_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        sample_valid;
  logic        error;
  logic [31:0] sample;

  wishbone_b3 wb();

  spi_poll_ctrl #(
    .PERIOD (32'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master       (wb),
    .enable       (enable),
    .start        (start),
    .busy         (busy),
    .sample       (sample),
    .sample_valid (sample_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] dat;
    int          t_start;
    int          t_end;
  } xact_t;

  xact_t       log_q[$];
  int          sv_t[$];
  int          cyc_n = 0;
  int          cur_start = 0;
  logic        prev_cyc = 1'b0;
  int          sv_n = 0;
  int          err_n = 0;
  int          bsy_left = 0;
  bit          bsy_stuck = 1'b0;
  bit          err_arm = 1'b0;
  logic [4:0]  err_adr = 5'h00;
  logic [31:0] rx_val = 32'h0;

  assign wb.rty = 1'b0;

  // Slave model: answers each access one cycle after seeing it and logs it.
  always @(posedge clk) begin
    cyc_n++;
    if (sample_valid) begin
      sv_n++;
      sv_t.push_back(cyc_n);
    end
    if (error) err_n++;
    if (wb.cyc && !prev_cyc) cur_start = cyc_n;
    if (wb.cyc && wb.ack)
      log_q.push_back('{wb.adr, wb.we, wb.we ? wb.dat_m2s : wb.dat_s2m, cur_start, cyc_n});
    prev_cyc = wb.cyc;
    if (rst) begin
      wb.ack     <= 1'b0;
      wb.err     <= 1'b0;
      wb.dat_s2m <= '0;
    end else begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      if (wb.cyc && wb.stb && !wb.ack && !wb.err) begin
        if (err_arm && wb.we && wb.adr == err_adr) begin
          wb.err <= 1'b1;
          err_arm = 1'b0;
        end else begin
          wb.ack <= 1'b1;
          if (!wb.we && wb.adr == 5'h10) begin
            if (bsy_stuck || bsy_left > 0) begin
              wb.dat_s2m <= 32'h0000_0100;
              if (bsy_left > 0) bsy_left--;
            end else begin
              wb.dat_s2m <= 32'h0000_0000;
            end
          end else if (!wb.we) begin
            wb.dat_s2m <= rx_val;
          end else begin
            wb.dat_s2m <= 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  function automatic int n_polls();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].adr == 5'h10 && !log_q[i].we) n++;
    return n;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sv(input int target, input int budget, input string tag);
    int k = 0;
    while (sv_n < target && k < budget) begin @(negedge clk); k++; end
    check_eq(tag, 32'(sv_n >= target), 32'd1);
  endtask

  task automatic wait_error(input int budget, input string tag);
    int k = 0;
    while (error !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check_eq(tag, 32'(error), 32'd1);
  endtask

  task automatic wait_polls(input int target, input int budget, input string tag);
    int k = 0;
    while (n_polls() < target && k < budget) begin @(negedge clk); k++; end
    check_eq(tag, 32'(n_polls() >= target), 32'd1);
  endtask

  logic [4:0]  exp_adr[6] = '{5'h14, 5'h18, 5'h00, 5'h10, 5'h10, 5'h00};
  logic        exp_we[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] exp_dat[6] = '{32'h4, 32'h1, 32'h0, 32'h0000_2510, 32'h0, 32'h0000_1A2B};

  initial begin
    int t0;
    int sv0;
    int e0;
    int np;

    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(wb.cyc), 32'd0);
    check_eq("rst_stb", 32'(wb.stb), 32'd0);
    check_eq("rst_we", 32'(wb.we), 32'd0);
    check_eq("rst_adr", 32'(wb.adr), 32'd0);
    check_eq("rst_dat", wb.dat_m2s, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sample", sample, 32'd0);
    check_eq("rst_sv", 32'(sample_valid), 32'd0);
    check_eq("rst_err", 32'(error), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("sel", 32'(wb.sel), 32'hF);

    // Basic poll: register writes in order, single POLL read, RX capture.
    rx_val = 32'h0000_1A2B;
    log_q.delete();
    t0 = cyc_n;
    sv0 = sv_n;
    pulse_start();
    check_eq("t1_busy_early", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_sv(sv0 + 1, 200, "t1_done");
    check_eq("t1_sample", sample, 32'h0000_1A2B);
    check_eq("t1_nxact", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        check_eq($sformatf("t1_adr%0d", i), 32'(log_q[i].adr), 32'(exp_adr[i]));
        check_eq($sformatf("t1_we%0d", i), 32'(log_q[i].we), 32'(exp_we[i]));
        check_eq($sformatf("t1_dat%0d", i), log_q[i].dat, exp_dat[i]);
      end
    end
    if (log_q.size() > 0) check_eq("t1_launch", 32'(log_q[0].t_start - t0), 32'd3);
    for (int i = 1; i < log_q.size(); i++)
      check_eq($sformatf("t1_gap%0d", i), 32'(log_q[i].t_start - log_q[i-1].t_end - 1), 32'd1);
    if (sv_t.size() > sv0) check_eq("t1_sv_time", 32'(sv_t[sv0] - t0), 32'd21);
    repeat (10) @(negedge clk);
    check_eq("t1_sv_once", 32'(sv_n - sv0), 32'd1);

    // GO_BSY busy three times, upper RX bits masked off.
    rx_val = 32'hFFFF_5A5A;
    bsy_left = 3;
    log_q.delete();
    sv0 = sv_n;
    pulse_start();
    wait_sv(sv0 + 1, 300, "t2_done");
    check_eq("t2_polls", 32'(n_polls()), 32'd4);
    check_eq("t2_nxact", 32'(log_q.size()), 32'd9);
    for (int i = 5; i < 8; i++)
      if (i < log_q.size())
        check_eq($sformatf("t2_pgap%0d", i), 32'(log_q[i].t_start - log_q[i-1].t_end - 1), 32'd1);
    if (log_q.size() == 9) begin
      check_eq("t2_last_adr", 32'(log_q[8].adr), 32'h00);
      check_eq("t2_last_we", 32'(log_q[8].we), 32'd0);
    end
    check_eq("t2_sample", sample, 32'h0000_5A5A);

    // Bus error on the CTRL write.
    err_arm = 1'b1;
    err_adr = 5'h10;
    log_q.delete();
    sv0 = sv_n;
    e0 = err_n;
    pulse_start();
    wait_error(200, "t3_error");
    check_eq("t3_cyc", 32'(wb.cyc), 32'd0);
    check_eq("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t3_err_pulse", 32'(error), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("t3_err_cnt", 32'(err_n - e0), 32'd1);
    check_eq("t3_no_sv", 32'(sv_n - sv0), 32'd0);
    check_eq("t3_sample", sample, 32'h0000_5A5A);
    check_eq("t3_nxact", 32'(log_q.size()), 32'd3);
    err_arm = 1'b0;

    // Three extra starts while busy merge into one follow-up poll.
    sv0 = sv_n;
    pulse_start();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      repeat (2) @(negedge clk);
    end
    check_eq("t4_busy", 32'(busy), 32'd1);
    repeat (120) @(negedge clk);
    check_eq("t4_sv_cnt", 32'(sv_n - sv0), 32'd2);
    check_eq("t4_idle", 32'(busy), 32'd0);

    // Periodic polling, first tick coinciding with a start pulse.
    rx_val = 32'h0000_0042;
    sv0 = sv_n;
    enable = 1'b1;
    t0 = cyc_n;
    repeat (99) @(negedge clk);
    pulse_start();
    repeat (250) @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("t5_sv_cnt", 32'(sv_n - sv0), 32'd3);
    if (sv_t.size() >= sv0 + 3) begin
      check_eq("t5_first", 32'(sv_t[sv0] - t0), 32'd120);
      check_eq("t5_space1", 32'(sv_t[sv0+1] - sv_t[sv0]), 32'd100);
      check_eq("t5_space2", 32'(sv_t[sv0+2] - sv_t[sv0+1]), 32'd100);
    end
    check_eq("t5_sample", sample, 32'h0000_0042);

    // Reset in the middle of a POLL access.
    bsy_stuck = 1'b1;
    log_q.delete();
    sv0 = sv_n;
    pulse_start();
    wait_polls(2, 200, "t6_polling");
    begin
      int k = 0;
      while (wb.cyc !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    end
    check_eq("t6_in_access", 32'(wb.cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_cyc", 32'(wb.cyc), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_sample", sample, 32'd0);
    rst = 1'b0;
    bsy_stuck = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t6_no_sv", 32'(sv_n - sv0), 32'd0);
    check_eq("t6_stay_idle", 32'(busy), 32'd0);

`ifdef SPI_POLL_TIMEOUT_EN
    // GO_BSY stuck: abort after 1024 reads.
    bsy_stuck = 1'b1;
    log_q.delete();
    sv0 = sv_n;
    e0 = err_n;
    pulse_start();
    wait_error(5000, "t7_timeout");
    np = n_polls();
    check_eq("t7_polls", 32'(np), 32'd1024);
    check_eq("t7_cyc", 32'(wb.cyc), 32'd0);
    bsy_stuck = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t7_err_cnt", 32'(err_n - e0), 32'd1);
    check_eq("t7_no_sv", 32'(sv_n - sv0), 32'd0);
`else
    np = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms expected finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_poll_ctrl.md
SPI_POLL_CTRL -- requirements
Module: spi_poll_ctrl

Interface
REQ-001 SHALL have parameter DIVIDER, default 16'd4, written to the SPI core DIVIDER register (SCLK = clk/((DIVIDER+1)*2)).
REQ-002 SHALL have parameter CHAR_LEN, default 7'd16, the transfer length in bits; legal range 1..32.
REQ-003 SHALL have parameter SS_MASK, default 8'h01, the slave-select pattern written to the SS register.
REQ-004 SHALL have parameter PERIOD, default 32'd1_000_000, the clk cycles between automatic polls; legal range 64 or more.
REQ-005 SHALL have parameter TX_WORD, default 32'h0, the data shifted out on MOSI during each poll.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port master, wishbone_b3.master, n/a: single-beat Wishbone master to the SPI core (adr 5 bits, data 32 bits).
REQ-009 SHALL have port enable, input, 1 bit: enables periodic polling.
REQ-010 SHALL have port start, input, 1 bit: one-cycle request for an immediate poll.
REQ-011 SHALL have port busy, output, 1 bit: high while a poll sequence is in progress.
REQ-012 SHALL have port sample, output, 32 bits: last RX0 value, masked to CHAR_LEN bits.
REQ-013 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample updates.
REQ-014 SHALL have port error, output, 1 bit: one-cycle pulse when a sequence aborts.

Function
REQ-015 SHALL drive master.sel = 4'hF; the controller is the only master on the bus, and master.rty is treated as ignored.
REQ-016 SHALL hold cyc/stb/we/adr/dat_m2s stable from assertion until the first cycle with ack or err, then deassert cyc/stb on the next edge; bus accesses are never back-to-back.
REQ-017 SHALL sequence the FSM as IDLE -> WR_DIV (0x14) -> WR_SS (0x18) -> WR_TX (0x00) -> WR_CTRL (0x10) -> POLL (read 0x10) -> RD_RX (read 0x00) -> DONE -> IDLE.
REQ-018 SHALL write CTRL with CHAR_LEN in [6:0], GO_BSY bit 8 = 1, TX_NEG bit 10 = 1, ASS bit 13 = 1, and all other bits 0.
REQ-019 SHALL repeat the POLL read until the returned bit 8 is 0, inserting exactly one idle cycle between reads.
REQ-020 SHALL, in DONE, register sample = RX0 & ((1<<CHAR_LEN)-1) and pulse sample_valid for exactly 1 cycle.
REQ-021 SHALL run a period counter only while enable=1: it loads PERIOD-1, decrements each cycle, raises a tick at 0 and reloads; deasserting enable clears it to PERIOD-1.
REQ-022 SHALL hold one pending request flag, set by start or tick and cleared on leaving IDLE; a start or tick arriving while busy sets it (one deep, further requests are merged).
REQ-023 SHALL leave IDLE on the cycle after the pending flag is observed set, with first cyc assertion in that same cycle; busy = (state != IDLE).
REQ-024 SHALL, on err in any bus cycle, drop cyc/stb, pulse error, return to IDLE, and leave sample unchanged.
REQ-025 SHALL, when start and tick coincide, produce a single poll.

Reset
REQ-026 SHALL on rst set: state IDLE, cyc=stb=we=0, adr=0, dat_m2s=0, sample=0, sample_valid=0, error=0, busy=0, pending=0, counter=PERIOD-1.
REQ-027 SHALL, when rst is asserted mid-transaction, deassert cyc/stb on the same edge and discard any partial result.

Configuration
REQ-028 SHALL, with SPI_POLL_TIMEOUT_EN defined, count POLL reads and abort as in REQ-024 after 1024 reads with bit 8 still set.
REQ-029 SHALL, without SPI_POLL_TIMEOUT_EN, poll without limit and contain no timeout counter logic.

Structure
REQ-030 SHALL place the register offsets (RX0/TX0 0x00, CTRL 0x10, DIVIDER 0x14, SS 0x18), CTRL bit positions and the FSM state enum in package spi_poll_pkg.
REQ-031 SHALL implement the period counter as sub-module spi_poll_timer (ports clk, rst, enable, tick); the FSM and bus logic stay in spi_poll_ctrl.

Verification
REQ-032 SHALL cover: start pulse with a BFM acking in 1 cycle and RX0=32'h0000_1A2B -> writes 0x14/0x18/0x00/0x10 in order with CTRL data 32'h0000_2510, then sample=32'h0000_1A2B and one sample_valid pulse.
REQ-033 SHALL cover: GO_BSY read as 1 three times, then 0 -> exactly 4 POLL reads, each separated by 1 idle cycle, then RD_RX.
REQ-034 SHALL cover: PERIOD=100, enable held high -> sample_valid pulses spaced exactly 100 cycles apart when the sequence is shorter than 100 cycles.
REQ-035 SHALL cover: err asserted on WR_CTRL -> one error pulse, cyc=0 the next cycle, sample unchanged, no sample_valid.
REQ-036 SHALL cover: start pulsed 3 times while busy -> exactly one additional poll after the current one completes.
REQ-037 SHALL cover: rst asserted during POLL -> cyc=0 and busy=0 after that edge; SPI_POLL_TIMEOUT_EN build with GO_BSY stuck at 1 -> error after 1024 reads.
